// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline boundary register:
// control-vector layout, handshake states and the bubble value.
package pipe_pkg;

   localparam int CTRL_W = 9;

   // Bit positions inside the control vector
   localparam int CTRL_REG_DEST   = 8;
   localparam int CTRL_BRANCH     = 7;
   localparam int CTRL_MEM_READ   = 6;
   localparam int CTRL_MEM_TO_REG = 5;
   localparam int CTRL_ALU_OP1    = 4;
   localparam int CTRL_ALU_OP2    = 3;
   localparam int CTRL_MEM_WRITE  = 2;
   localparam int CTRL_ALU_SRC    = 1;
   localparam int CTRL_REG_WRITE  = 0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   // Bubble: no write, no branch, no memory access
   localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_skid_slot.sv
// Second holding entry of a pipe_stage: one register
// with load, clear and an occupancy flag.
module pipe_skid_slot
   import pipe_pkg::*;
#(
   parameter int W = 73
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         vld
);

   logic [W-1:0] ent_q, ent_d;
   logic         vld_q, vld_d;

   // Load captures a new entry; clear empties the slot
   always_comb begin
      ent_d = ent_q;
      vld_d = vld_q;
      if (clear) begin
         vld_d = 1'b0;
      end else if (load) begin
         ent_d = d;
         vld_d = 1'b1;
      end
   end

   // Slot registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ent_q <= '0;
         vld_q <= 1'b0;
      end else begin
         ent_q <= ent_d;
         vld_q <= vld_d;
      end
   end

   assign q   = ent_q;
   assign vld = vld_q;

endmodule

// File: rtl/pipe_stage.sv
// Pipeline boundary register with valid/ready, flush/bubble
// and a saturating stall counter. Skid entry: PIPE_STAGE_SKID_EN.
module pipe_stage #(
   parameter int DATA_W      = 32,
   parameter int PC_W        = 32,
   parameter int CTRL_W      = pipe_pkg::CTRL_W,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   input  logic [PC_W-1:0]        in_pc,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [PC_W-1:0]        out_pc,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   import pipe_pkg::*;

   localparam int ENT_W = DATA_W + PC_W + CTRL_W;

   state_e                 state_q, state_d;
   logic [ENT_W-1:0]       main_q, main_d;
   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
   logic [ENT_W-1:0]       in_ent;
   logic                   in_xfer;
   logic                   out_xfer;

   assign in_ent   = {in_data, in_pc, in_ctrl};
   assign out_valid = (state_q != ST_EMPTY);
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic             rdy_q, rdy_d;
   logic             skid_load;
   logic             skid_clr;
   logic             skid_vld;
   logic [ENT_W-1:0] skid_ent;

   // Registered ready cuts the backward ready chain
   assign in_ready = rst_n & rdy_q;

   pipe_skid_slot #(
      .W (ENT_W)
   ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load),
      .clear (skid_clr),
      .d     (in_ent),
      .q     (skid_ent),
      .vld   (skid_vld)
   );
`else
   assign in_ready = rst_n & (out_ready | ~out_valid);
`endif

   // Next state and main-register load; flush empties everything
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
      skid_load = 1'b0;
      skid_clr  = 1'b0;
`endif
      unique case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               main_d  = in_ent;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (in_xfer && out_xfer) begin
               main_d = in_ent;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
            end else if (in_xfer) begin
               skid_load = 1'b1;
               state_d   = ST_SKID;
`endif
            end
         end
`ifdef PIPE_STAGE_SKID_EN
         ST_SKID: begin
            if (out_xfer && skid_vld) begin
               main_d   = skid_ent;
               skid_clr = 1'b1;
               state_d  = ST_FULL;
            end
         end
`endif
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
         skid_load = 1'b0;
         skid_clr  = 1'b1;
`endif
      end
   end

`ifdef PIPE_STAGE_SKID_EN
   // Ready for the next cycle: room unless both entries are held
   always_comb begin
      rdy_d = (state_d != ST_SKID);
   end
`endif

   // Saturating count of stalled output cycles
   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && !out_ready && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State, main entry and counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         cnt_q   <= '0;
`ifdef PIPE_STAGE_SKID_EN
         rdy_q   <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         cnt_q   <= cnt_d;
`ifdef PIPE_STAGE_SKID_EN
         rdy_q   <= rdy_d;
`endif
      end
   end

   assign out_data  = main_q[ENT_W-1 -: DATA_W];
   assign out_pc    = main_q[CTRL_W +: PC_W];
   assign out_ctrl  = out_valid ? main_q[CTRL_W-1:0]
                                : CTRL_W'(CTRL_BUBBLE);
   assign stall_cnt = cnt_q;

endmodule
